// File: rtl/h264_mb_fetch.sv
// Macroblock fetch unit: walks a planar frame in MB raster order, reads words
// through a request/grant port under a credit limit and streams them out with MB position tags.
module h264_mb_fetch #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DIM_W      = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int MB_W       = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              chroma_en_i,
    input  logic [DIM_W-1:0]  frame_width_i,
    input  logic [DIM_W-1:0]  frame_height_i,
    input  logic [ADDR_W-1:0] y_base_i,
    input  logic [ADDR_W-1:0] cb_base_i,
    input  logic [ADDR_W-1:0] cr_base_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              data_valid_o,
    output logic [DATA_W-1:0] data_word_o,
    input  logic              fetch_req_i,
    output logic [MB_W-1:0]   mb_x_o,
    output logic [MB_W-1:0]   mb_y_o,
    output logic              mb_last_o,
    output logic              frame_done_o,
    output logic              busy_o,
    output logic [2:0]        dbg_state_o
);
    localparam int PPW    = DATA_W / 8;
    localparam int PPW_SH = $clog2(PPW);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [3:0]        LW_M1    = 4'(16 / PPW - 1);
    localparam logic [3:0]        CW_M1    = 4'(8 / PPW - 1);
    localparam logic [ADDR_W-1:0] LW_A     = ADDR_W'(16 / PPW);
    localparam logic [ADDR_W-1:0] CW_A     = ADDR_W'(8 / PPW);
    localparam logic [8:0]        WPM_L_M1 = 9'(256 / PPW - 1);
    localparam logic [8:0]        WPM_C_M1 = 9'(384 / PPW - 1);
    localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_LUMA, S_CB, S_CR, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              chroma_q, chroma_d, zero_q, zero_d, frame_done_q, frame_done_d;
    logic [DIM_W-1:0]  mbs_x_q, mbs_x_d, mbs_y_q, mbs_y_d;
    logic [DIM_W-1:0]  req_mbx_q, req_mbx_d, req_mby_q, req_mby_d;
    logic [3:0]        row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] lstride_q, lstride_d, cstride_q, cstride_d;
    logic [ADDR_W-1:0] ybase_q, ybase_d, cbbase_q, cbbase_d, crbase_q, crbase_d;
    logic [ADDR_W-1:0] l_mbrow_q, l_mbrow_d, l_mb_q, l_mb_d, l_row_q, l_row_d;
    logic [ADDR_W-1:0] c_mbrow_q, c_mbrow_d, c_mb_q, c_mb_d, c_row_q, c_row_d;
    logic [ADDR_W-1:0] l_next_mbrow, c_next_mbrow;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, outst_q, outst_d;
    logic [CNT_W:0]    inflight;
    logic [8:0]        out_word_q, out_word_d, wpm_m1;
    logic [DIM_W-1:0]  out_mbx_q, out_mbx_d, out_mby_q, out_mby_d;
    logic              credit_ok, grant, push, pop, last_pop, start_acc, advance_mb;

    // Stream handshake: a word moves on data_valid_o && fetch_req_i; data_word_o and the
    // MB tags describe the FIFO head and only change when that word moves.
    assign push         = mem_rvalid_i;
    assign data_valid_o = (cnt_q != '0);
    assign pop          = data_valid_o && fetch_req_i;
    assign data_word_o  = data_valid_o ? fifo_mem[rd_q] : '0;
    assign wpm_m1       = chroma_q ? WPM_C_M1 : WPM_L_M1;
    assign mb_x_o       = out_mbx_q[MB_W-1:0];
    assign mb_y_o       = out_mby_q[MB_W-1:0];
    assign mb_last_o    = (out_word_q == wpm_m1);
    assign last_pop     = pop && mb_last_o && (out_mbx_q == mbs_x_q - DIM_ONE)
                          && (out_mby_q == mbs_y_q - DIM_ONE);
    assign frame_done_o = frame_done_q;
    assign busy_o       = (state_q != S_IDLE);
    assign dbg_state_o  = state_q;

    // Every granted read owns a FIFO slot until it is popped, so the FIFO cannot overflow.
    assign inflight     = {1'b0, outst_q} + {1'b0, cnt_q};
    assign credit_ok    = (inflight < (CNT_W + 1)'(FIFO_DEPTH));
    assign grant        = mem_req_o && mem_gnt_i;
    assign l_next_mbrow = l_mbrow_q + (lstride_q << 4);
    assign c_next_mbrow = c_mbrow_q + (cstride_q << 3);

    always_comb begin
        state_d      = state_q;
        chroma_d     = chroma_q;
        zero_d       = zero_q;
        frame_done_d = 1'b0;
        mbs_x_d      = mbs_x_q;
        mbs_y_d      = mbs_y_q;
        req_mbx_d    = req_mbx_q;
        req_mby_d    = req_mby_q;
        row_d        = row_q;
        col_d        = col_q;
        lstride_d    = lstride_q;
        cstride_d    = cstride_q;
        ybase_d      = ybase_q;
        cbbase_d     = cbbase_q;
        crbase_d     = crbase_q;
        l_mbrow_d    = l_mbrow_q;
        l_mb_d       = l_mb_q;
        l_row_d      = l_row_q;
        c_mbrow_d    = c_mbrow_q;
        c_mb_d       = c_mb_q;
        c_row_d      = c_row_q;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        start_acc    = 1'b0;
        advance_mb   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    chroma_d  = chroma_en_i;
                    zero_d    = (frame_width_i == '0) || (frame_height_i == '0);
                    mbs_x_d   = frame_width_i >> 4;
                    mbs_y_d   = frame_height_i >> 4;
                    lstride_d = ADDR_W'(frame_width_i) >> PPW_SH;
                    cstride_d = ADDR_W'(frame_width_i) >> (PPW_SH + 1);
                    ybase_d   = y_base_i;
                    cbbase_d  = cb_base_i;
                    crbase_d  = cr_base_i;
                    req_mbx_d = '0;
                    req_mby_d = '0;
                    row_d     = '0;
                    col_d     = '0;
                    l_mbrow_d = '0;
                    l_mb_d    = '0;
                    l_row_d   = '0;
                    c_mbrow_d = '0;
                    c_mb_d    = '0;
                    c_row_d   = '0;
                    state_d   = zero_d ? S_DONE : S_LUMA;
                end
            end
            S_LUMA: begin
                mem_req_o  = credit_ok;
                mem_addr_o = ybase_q + l_row_q + ADDR_W'(col_q);
                if (grant) begin
                    if (col_q != LW_M1) begin
                        col_d = col_q + 4'd1;
                    end else begin
                        col_d = '0;
                        if (row_q != 4'd15) begin
                            row_d   = row_q + 4'd1;
                            l_row_d = l_row_q + lstride_q;
                        end else begin
                            row_d = '0;
                            if (chroma_q) begin
                                state_d = S_CB;
                                c_row_d = c_mb_q;
                            end else begin
                                advance_mb = 1'b1;
                            end
                        end
                    end
                end
            end
            S_CB, S_CR: begin
                mem_req_o  = credit_ok;
                mem_addr_o = ((state_q == S_CB) ? cbbase_q : crbase_q) + c_row_q + ADDR_W'(col_q);
                if (grant) begin
                    if (col_q != CW_M1) begin
                        col_d = col_q + 4'd1;
                    end else begin
                        col_d = '0;
                        if (row_q != 4'd7) begin
                            row_d   = row_q + 4'd1;
                            c_row_d = c_row_q + cstride_q;
                        end else begin
                            row_d = '0;
                            if (state_q == S_CB) begin
                                state_d = S_CR;
                                c_row_d = c_mb_q;
                            end else begin
                                advance_mb = 1'b1;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                if (zero_q || last_pop) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (advance_mb) begin
            if (req_mbx_q == mbs_x_q - DIM_ONE) begin
                req_mbx_d = '0;
                if (req_mby_q == mbs_y_q - DIM_ONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_LUMA;
                    req_mby_d = req_mby_q + DIM_ONE;
                    l_mbrow_d = l_next_mbrow;
                    l_mb_d    = l_next_mbrow;
                    l_row_d   = l_next_mbrow;
                    c_mbrow_d = c_next_mbrow;
                    c_mb_d    = c_next_mbrow;
                end
            end else begin
                state_d   = S_LUMA;
                req_mbx_d = req_mbx_q + DIM_ONE;
                l_mb_d    = l_mb_q + LW_A;
                l_row_d   = l_mb_q + LW_A;
                c_mb_d    = c_mb_q + CW_A;
            end
        end
    end

    // Output-side position counters follow the FIFO head, independent of the request walk.
    always_comb begin
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        outst_d    = outst_q;
        out_word_d = out_word_q;
        out_mbx_d  = out_mbx_q;
        out_mby_d  = out_mby_q;
        if (push) wr_d = wr_q + PTR_ONE;
        if (pop)  rd_d = rd_q + PTR_ONE;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        case ({grant, mem_rvalid_i})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase
        if (start_acc) begin
            out_word_d = '0;
            out_mbx_d  = '0;
            out_mby_d  = '0;
        end else if (pop) begin
            if (mb_last_o) begin
                out_word_d = '0;
                if (out_mbx_q == mbs_x_q - DIM_ONE) begin
                    out_mbx_d = '0;
                    out_mby_d = (out_mby_q == mbs_y_q - DIM_ONE) ? '0 : out_mby_q + DIM_ONE;
                end else begin
                    out_mbx_d = out_mbx_q + DIM_ONE;
                end
            end else begin
                out_word_d = out_word_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_q] <= mem_rdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            chroma_q     <= 1'b0;
            zero_q       <= 1'b0;
            frame_done_q <= 1'b0;
            mbs_x_q      <= '0;
            mbs_y_q      <= '0;
            req_mbx_q    <= '0;
            req_mby_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            lstride_q    <= '0;
            cstride_q    <= '0;
            ybase_q      <= '0;
            cbbase_q     <= '0;
            crbase_q     <= '0;
            l_mbrow_q    <= '0;
            l_mb_q       <= '0;
            l_row_q      <= '0;
            c_mbrow_q    <= '0;
            c_mb_q       <= '0;
            c_row_q      <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            outst_q      <= '0;
            out_word_q   <= '0;
            out_mbx_q    <= '0;
            out_mby_q    <= '0;
        end else begin
            state_q      <= state_d;
            chroma_q     <= chroma_d;
            zero_q       <= zero_d;
            frame_done_q <= frame_done_d;
            mbs_x_q      <= mbs_x_d;
            mbs_y_q      <= mbs_y_d;
            req_mbx_q    <= req_mbx_d;
            req_mby_q    <= req_mby_d;
            row_q        <= row_d;
            col_q        <= col_d;
            lstride_q    <= lstride_d;
            cstride_q    <= cstride_d;
            ybase_q      <= ybase_d;
            cbbase_q     <= cbbase_d;
            crbase_q     <= crbase_d;
            l_mbrow_q    <= l_mbrow_d;
            l_mb_q       <= l_mb_d;
            l_row_q      <= l_row_d;
            c_mbrow_q    <= c_mbrow_d;
            c_mb_q       <= c_mb_d;
            c_row_q      <= c_row_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            outst_q      <= outst_d;
            out_word_q   <= out_word_d;
            out_mbx_q    <= out_mbx_d;
            out_mby_q    <= out_mby_d;
        end
    end
endmodule

// File: tb/tb_h264_mb_fetch.sv
// Bench for h264_mb_fetch: random memory latency/grant/backpressure against an
// address-formula reference of the expected request and stream order.
module tb_h264_mb_fetch;
    localparam int DATA_W = 32, ADDR_W = 32, DIM_W = 12, FIFO_DEPTH = 8, MB_W = 6;
    localparam int PPW = DATA_W / 8;
    localparam int NEVER = 32'h7fff_ffff;

    logic clk, rst_n, start, chroma_en;
    logic [DIM_W-1:0] frame_width, frame_height;
    logic [ADDR_W-1:0] y_base, cb_base, cr_base, mem_addr;
    logic mem_req, mem_gnt, mem_rvalid, data_valid, fetch_req, mb_last, frame_done, busy;
    logic [DATA_W-1:0] mem_rdata, data_word;
    logic [MB_W-1:0] mb_x, mb_y;
    logic [2:0] dbg_state;

    h264_mb_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W),
                    .FIFO_DEPTH(FIFO_DEPTH), .MB_W(MB_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .chroma_en_i(chroma_en),
        .frame_width_i(frame_width), .frame_height_i(frame_height),
        .y_base_i(y_base), .cb_base_i(cb_base), .cr_base_i(cr_base),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .data_valid_o(data_valid), .data_word_o(data_word), .fetch_req_i(fetch_req),
        .mb_x_o(mb_x), .mb_y_o(mb_y), .mb_last_o(mb_last),
        .frame_done_o(frame_done), .busy_o(busy), .dbg_state_o(dbg_state)
    );

    // Clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int checks = 0, errors = 0;
    logic [DATA_W-1:0]  exp_q[$];
    logic [2*MB_W:0]    exp_meta_q[$];
    logic [ADDR_W-1:0]  exp_req_q[$];
    logic [DATA_W-1:0]  rd_q[$];
    int rdy_q[$];
    int last_ready = 0;
    int gnt_mode = 0, fetch_mode = 0, lat_max = 1, stall_cnt = 0;
    int done_cyc = NEVER, busy_start = -1;
    bit in_frame = 0, done_seen = 0;
    int grants = 0, xfers = 0, xfer_total = 0, frame_grants = 0;
    logic prev_req = 0, prev_gnt = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] ew;
    logic [2*MB_W:0] em;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h (cycle %0d)", name, act, cyc);
    endtask

    // Reference: expected request/stream order straight from the plane address formulas.
    task automatic push_word(input logic [ADDR_W-1:0] a, input int mx, input int my, input bit last);
        exp_q.push_back(DATA_W'(a));
        exp_req_q.push_back(a);
        exp_meta_q.push_back({MB_W'(mx), MB_W'(my), last});
    endtask

    task automatic build_model(input int w, input int h, input bit ch,
                               input logic [ADDR_W-1:0] yb, input logic [ADDR_W-1:0] cb,
                               input logic [ADDR_W-1:0] cr);
        int wpm, k;
        exp_q.delete();
        exp_req_q.delete();
        exp_meta_q.delete();
        wpm = ch ? 384 / PPW : 256 / PPW;
        for (int my = 0; my < h / 16; my++)
            for (int mx = 0; mx < w / 16; mx++) begin
                k = 0;
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16 / PPW; c++) begin
                        push_word(yb + ADDR_W'((my * 16 + r) * (w / PPW) + mx * (16 / PPW) + c),
                                  mx, my, k == wpm - 1);
                        k++;
                    end
                if (ch)
                    for (int p = 0; p < 2; p++)
                        for (int r = 0; r < 8; r++)
                            for (int c = 0; c < 8 / PPW; c++) begin
                                push_word((p == 0 ? cb : cr) +
                                          ADDR_W'((my * 8 + r) * (w / (2 * PPW)) + mx * (8 / PPW) + c),
                                          mx, my, k == wpm - 1);
                                k++;
                            end
            end
    endtask

    // Memory model and stream consumer: drive inputs 1 time unit after the edge.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            rd_q.delete();
            rdy_q.delete();
            last_ready = 0;
            mem_rvalid = 1'b0;
        end else if (rdy_q.size() > 0 && rdy_q[0] <= cyc + 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_q.pop_front();
            void'(rdy_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        if (stall_cnt > 0) begin
            mem_gnt = 1'b0;
            stall_cnt--;
        end else if (gnt_mode == 0) mem_gnt = 1'b1;
        else mem_gnt = ($urandom_range(0, 3) != 0);
        fetch_req = (fetch_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    end

    // Compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_ctrl", {mem_req, data_valid, mb_x, mb_y, mb_last, frame_done, busy}, '0);
            check("reset_addr", mem_addr, '0);
            check("reset_word", data_word, '0);
            prev_req = 1'b0;
            grants = 0;
            xfers = 0;
        end else begin
            check("credit_limit", (grants - xfers <= FIFO_DEPTH), 1);
            if (prev_req && !prev_gnt) begin
                check("req_hold", mem_req, 1);
                check("addr_hold", mem_addr, prev_addr);
            end
            if (mem_req && exp_req_q.size() == 0) fail("req_without_work", mem_addr);
            if (mem_req && mem_gnt && exp_req_q.size() > 0) begin
                int r;
                check("req_addr", mem_addr, exp_req_q.pop_front());
                r = cyc + 1 + $urandom_range(1, lat_max);
                if (r <= last_ready) r = last_ready + 1;
                last_ready = r;
                rd_q.push_back(DATA_W'(mem_addr));
                rdy_q.push_back(r);
                grants++;
                frame_grants++;
            end
            if (data_valid && fetch_req) begin
                if (exp_q.size() == 0) fail("unexpected_word", data_word);
                else begin
                    ew = exp_q.pop_front();
                    em = exp_meta_q.pop_front();
                    check("data_word", data_word, ew);
                    check("mb_x", mb_x, em[2*MB_W:MB_W+1]);
                    check("mb_y", mb_y, em[MB_W:1]);
                    check("mb_last", mb_last, em[0]);
                    if (exp_q.size() == 0 && in_frame) done_cyc = cyc + 1;
                end
                xfers++;
                xfer_total++;
            end
            check("frame_done", frame_done, cyc == done_cyc);
            if (frame_done) done_seen = 1;
            check("busy", busy, busy_start >= 0 && cyc >= busy_start && cyc < done_cyc);
            prev_req  = mem_req;
            prev_gnt  = mem_gnt;
            prev_addr = mem_addr;
        end
    end

    // Driver tasks
    task automatic apply_reset(input int n);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp_req_q.delete();
        exp_meta_q.delete();
        in_frame = 0;
        busy_start = -1;
        done_cyc = NEVER;
        repeat (n) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic start_frame(input int w, input int h, input bit ch, input logic [ADDR_W-1:0] yb,
                               input logic [ADDR_W-1:0] cb, input logic [ADDR_W-1:0] cr);
        @(posedge clk);
        #2;
        frame_width = DIM_W'(w);
        frame_height = DIM_W'(h);
        chroma_en = ch;
        y_base = yb;
        cb_base = cb;
        cr_base = cr;
        start = 1'b1;
        busy_start = cyc + 1;
        in_frame = 1;
        done_seen = 0;
        frame_grants = 0;
        if (w == 0 || h == 0) done_cyc = cyc + 2;
        @(posedge clk);
        #2 start = 1'b0;
        frame_width = DIM_W'($urandom);
        frame_height = DIM_W'($urandom);
        chroma_en = $urandom_range(0, 1);
        y_base = $urandom;
        @(negedge clk);
        check("start_busy", busy, 1);
        if (w != 0 && h != 0) begin
            check("start_req", mem_req, 1);
            check("start_addr", mem_addr, yb);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!done_seen && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (!done_seen) begin
            fail("frame_timeout", exp_q.size());
            apply_reset(2);
        end
        check("leftover_words", exp_q.size(), 0);
        check("leftover_reqs", exp_req_q.size(), 0);
        in_frame = 0;
        busy_start = -1;
        done_cyc = NEVER;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; start = 1'b0; chroma_en = 1'b0;
        frame_width = '0; frame_height = '0; y_base = '0; cb_base = '0; cr_base = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; fetch_req = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;

        // Luma-only 32x16, data = address, ideal memory and consumer
        build_model(32, 16, 0, 32'h0, 32'h0, 32'h0);
        check("pin_size_luma", exp_q.size(), 128);
        check("pin_w4", exp_q[4], 8);
        check("pin_w63", exp_q[63], 123);
        em = exp_meta_q[63];
        check("pin_last63", em[0], 1);
        check("pin_mb1_start", exp_q[64], 4);
        em = exp_meta_q[64];
        check("pin_mb1_x", em[2*MB_W:MB_W+1], 1);
        start_frame(32, 16, 0, 32'h0, 32'h0, 32'h0);
        wait_frame();

        // Chroma 16x16
        build_model(16, 16, 1, 32'h0, 32'h100, 32'h200);
        check("pin_size_chroma", exp_q.size(), 96);
        check("pin_cb0", exp_q[64], 32'h100);
        check("pin_cb3", exp_q[67], 32'h103);
        check("pin_cr0", exp_q[80], 32'h200);
        em = exp_meta_q[94];
        check("pin_last94", em[0], 0);
        em = exp_meta_q[95];
        check("pin_last95", em[0], 1);
        start_frame(16, 16, 1, 32'h0, 32'h100, 32'h200);
        wait_frame();

        // Backpressure and random memory latency
        gnt_mode = 1; fetch_mode = 1; lat_max = 6;
        build_model(32, 16, 0, 32'h0, 32'h0, 32'h0);
        start_frame(32, 16, 0, 32'h0, 32'h0, 32'h0);
        wait_frame();
        for (int i = 0; i < 3; i++) begin
            int w, h;
            bit ch;
            logic [ADDR_W-1:0] yb, cb, cr;
            w = 16 * $urandom_range(1, 4);
            h = 16 * $urandom_range(1, 3);
            ch = $urandom_range(0, 1);
            yb = $urandom_range(0, 4095);
            cb = 32'h1_0000 + $urandom_range(0, 4095);
            cr = 32'h2_0000 + $urandom_range(0, 4095);
            build_model(w, h, ch, yb, cb, cr);
            start_frame(w, h, ch, yb, cb, cr);
            wait_frame();
        end

        // Grant stall of 5 cycles mid-frame
        gnt_mode = 0; fetch_mode = 0; lat_max = 2;
        build_model(32, 16, 1, 32'h40, 32'h500, 32'h600);
        start_frame(32, 16, 1, 32'h40, 32'h500, 32'h600);
        repeat (10) @(posedge clk);
        stall_cnt = 5;
        wait_frame();

        // Zero dimension
        build_model(32, 0, 0, 32'h0, 32'h0, 32'h0);
        start_frame(32, 0, 0, 32'h0, 32'h0, 32'h0);
        wait_frame();
        check("zero_no_grants", frame_grants, 0);

        // Reset mid-frame, then a fresh frame from a new base
        gnt_mode = 1; fetch_mode = 1; lat_max = 4;
        build_model(32, 16, 0, 32'h0, 32'h0, 32'h0);
        base = xfer_total;
        start_frame(32, 16, 0, 32'h0, 32'h0, 32'h0);
        for (int n = 0; n < 5000 && xfer_total < base + 20; n++) @(posedge clk);
        check("mid_reached_20", xfer_total >= base + 20, 1);
        apply_reset(3);
        build_model(32, 32, 0, 32'h80, 32'h0, 32'h0);
        em = exp_meta_q[0];
        check("pin_restart_mb", em[2*MB_W:1], 0);
        start_frame(32, 32, 0, 32'h80, 32'h0, 32'h0);
        wait_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
